// File: rtl/pe_row_skew_feeder.sv
// pe_row_skew_feeder: west-edge operand feeder for the PE systolic array.
// Accepts one LANES-wide row vector per handshake, tags it with the current
// propagate phase, zero-pads partial tiles, and skews lane i by i+1 cycles.
//
// Handshake: a vector transfers on a rising clock edge when io_in_valid and
// io_in_ready are both high; io_in_ready depends only on io_en, reset_n and
// the internal state (never on io_in_valid), and the producer must hold its
// vector stable until the transfer cycle.
module pe_row_skew_feeder #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int TILE  = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                io_en,
  input  logic                io_in_valid,
  output logic                io_in_ready,
  input  logic [LANES*DW-1:0] io_in_data,
  input  logic                io_in_last,
  output logic [LANES*DW-1:0] io_out_a,
  output logic [LANES-1:0]    io_out_valid,
  output logic [LANES-1:0]    io_out_control_propagate
);

  localparam int CW = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TILE - 1);
  // One skew stage word: {prop, valid, data}
  localparam int SW = DW + 2;

  typedef enum logic {
    STREAM = 1'b0,
    PAD    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic   [CW-1:0]     cnt_q, cnt_d;
  logic                prop_q, prop_d;
  logic                accept;
  logic                inj_valid;
  logic [LANES*DW-1:0] inj_data;

  // Ready drops combinationally with reset so nothing is accepted while held.
  assign io_in_ready = io_en & (state_q == STREAM) & reset_n;
  assign accept      = io_in_valid & io_in_ready;

  // Injection: accepted data, a zero pad vector, or a bubble.
  always_comb begin
    inj_valid = 1'b0;
    inj_data  = '0;
    if (state_q == PAD) begin
      inj_valid = 1'b1;
    end else if (accept) begin
      inj_valid = 1'b1;
      inj_data  = io_in_data;
    end
  end

  // Next-state: tile counter, propagate phase and pad FSM advance only on a
  // valid injection in an enabled cycle; the vector carries the old prop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prop_d  = prop_q;
    if (io_en && inj_valid) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        prop_d = ~prop_q;
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
      case (state_q)
        STREAM: if (io_in_last && (cnt_q != CNT_MAX)) state_d = PAD;
        PAD:    if (cnt_q == CNT_MAX) state_d = STREAM;
        default: state_d = STREAM;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STREAM;
      cnt_q   <= '0;
      prop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prop_q  <= prop_d;
    end
  end

  // Per-lane shift chains; lane i has i+1 stages so it lags lane 0 by i.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [SW-1:0] chain_q [0:i];
    logic [SW-1:0] chain_d [0:i];

    // Shift the lane's own {prop, valid, data} element one stage along.
    always_comb begin
      chain_d[0] = {prop_q, inj_valid, inj_data[i*DW +: DW]};
      for (int k = 1; k <= i; k++) begin
        chain_d[k] = chain_q[k-1];
      end
    end

    // Chain registers freeze whenever the array is disabled.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k <= i; k++) chain_q[k] <= '0;
      end else if (io_en) begin
        for (int k = 0; k <= i; k++) chain_q[k] <= chain_d[k];
      end
    end

    assign io_out_a[i*DW +: DW]        = chain_q[i][DW-1:0];
    assign io_out_valid[i]             = chain_q[i][DW];
    assign io_out_control_propagate[i] = chain_q[i][DW+1];
  end

endmodule

// File: tb/tb_pe_row_skew_feeder.sv
// Bench for pe_row_skew_feeder (LANES=4, DW=8, TILE=4).
module tb_pe_row_skew_feeder;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int TILE  = 4;
  localparam int W     = LANES*DW + 2;

  logic                clock;
  logic                reset_n;
  logic                io_en;
  logic                io_in_valid;
  logic                io_in_ready;
  logic [LANES*DW-1:0] io_in_data;
  logic                io_in_last;
  logic [LANES*DW-1:0] io_out_a;
  logic [LANES-1:0]    io_out_valid;
  logic [LANES-1:0]    io_out_control_propagate;

  pe_row_skew_feeder #(.LANES(LANES), .DW(DW), .TILE(TILE)) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .io_en                    (io_en),
    .io_in_valid              (io_in_valid),
    .io_in_ready              (io_in_ready),
    .io_in_data               (io_in_data),
    .io_in_last               (io_in_last),
    .io_out_a                 (io_out_a),
    .io_out_valid             (io_out_valid),
    .io_out_control_propagate (io_out_control_propagate)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  // exp_q holds the last LANES injections {prop, valid, data}; lane i output
  // is lane i of the entry i positions back from the newest.
  logic [W-1:0] exp_q[$];
  int checks;
  int failures;
  int total_inj;   // valid injections since reset
  int pad_left;    // pad vectors still owed

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        en;
    int          rdy;  // expected io_in_ready, -1 = not tabulated
    int          l0;   // expected lane0 {prop,valid,a}, -1 = not tabulated
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int enc(input logic p, input logic v, input logic [7:0] a);
    return int'(p)*512 + int'(v)*256 + int'(a);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < LANES; i++) exp_q.push_back('0);
    total_inj = 0;
    pad_left  = 0;
  endtask

  task automatic check_outputs();
    logic [W-1:0] w;
    for (int i = 0; i < LANES; i++) begin
      w = exp_q[exp_q.size()-1-i];
      chk($sformatf("lane%0d_a", i), 64'(io_out_a[i*DW +: DW]), 64'(w[i*DW +: DW]));
      chk($sformatf("lane%0d_valid", i), 64'(io_out_valid[i]), 64'(w[LANES*DW]));
      chk($sformatf("lane%0d_prop", i), 64'(io_out_control_propagate[i]), 64'(w[LANES*DW+1]));
    end
  endtask

  // One clock: drive inputs, check ready, predict injection, check outputs.
  task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                       input logic en, input int want_rdy, input int want_l0);
    logic         exp_rdy;
    logic         acc;
    logic         p;
    logic [W-1:0] inj;
    logic [9:0]   l0_act;
    int           pos;
    io_in_valid = v;
    io_in_data  = d;
    io_in_last  = l;
    io_en       = en;
    #1;
    exp_rdy = en && (pad_left == 0) && reset_n;
    chk("in_ready", 64'(io_in_ready), 64'(exp_rdy));
    if (want_rdy >= 0) chk("tbl_ready", 64'(io_in_ready), 64'(want_rdy));
    acc = v && exp_rdy;
    p   = ((total_inj / TILE) % 2) == 1;
    if (pad_left > 0)  inj = {p, 1'b1, 32'h0};
    else if (acc)      inj = {p, 1'b1, d};
    else               inj = {p, 1'b0, 32'h0};
    @(posedge clock);
    if (en) begin
      exp_q.push_back(inj);
      if (exp_q.size() > LANES) void'(exp_q.pop_front());
      if (inj[LANES*DW]) begin
        pos = total_inj % TILE;
        if (pad_left > 0) pad_left--;
        else if (l && pos != TILE-1) pad_left = TILE-1-pos;
        total_inj++;
      end
    end
    #1;
    check_outputs();
    if (want_l0 >= 0) begin
      l0_act = {io_out_control_propagate[0], io_out_valid[0], io_out_a[7:0]};
      chk("tbl_lane0", 64'(l0_act), 64'(want_l0[9:0]));
    end
  endtask

  task automatic add(input logic v, input logic [31:0] d, input logic l,
                     input logic en, input int rdy, input int l0);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.en = en; r.rdy = rdy; r.l0 = l0;
    tbl.push_back(r);
  endtask

  task automatic run_tbl();
    for (int k = 0; k < tbl.size(); k++)
      cycle(tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].en, tbl[k].rdy, tbl[k].l0);
    tbl.delete();
  endtask

  // Pulse reset between edges; outputs and control state must clear at once.
  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_out_a", 64'(io_out_a), 64'(0));
    chk("rst_out_valid", 64'(io_out_valid), 64'(0));
    chk("rst_out_prop", 64'(io_out_control_propagate), 64'(0));
    chk("rst_ready", 64'(io_in_ready), 64'(0));
    chk("rst_cnt", 64'(dut.cnt_q), 64'(0));
    chk("rst_prop_reg", 64'(dut.prop_q), 64'(0));
    chk("rst_state", 64'(dut.state_q), 64'(0));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] dv;
    checks = 0; failures = 0;
    reset_n = 1'b0; io_en = 1'b0; io_in_valid = 1'b0; io_in_data = '0; io_in_last = 1'b0;
    model_reset();

    // 1: reset held with random inputs
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      io_en       = 1'($urandom_range(0, 1));
      io_in_valid = 1'($urandom_range(0, 1));
      io_in_last  = 1'($urandom_range(0, 1));
      io_in_data  = $urandom;
      #1;
      chk("hold_rst_a", 64'(io_out_a), 64'(0));
      chk("hold_rst_valid", 64'(io_out_valid), 64'(0));
      chk("hold_rst_prop", 64'(io_out_control_propagate), 64'(0));
      chk("hold_rst_ready", 64'(io_in_ready), 64'(0));
    end
    io_in_valid = 1'b0;
    reset_n = 1'b1; io_en = 1'b1; #1;
    chk("release_ready_en1", 64'(io_in_ready), 64'(1));
    io_en = 1'b0; #1;
    chk("release_ready_en0", 64'(io_in_ready), 64'(0));
    model_reset();

    // 2: single vector skew, explicit constants per lane and cycle
    for (int k = 0; k < 6; k++) begin
      if (k == 0) cycle(1'b1, 32'h04030201, 1'b0, 1'b1, 1, -1);
      else        cycle(1'b0, 32'hdeadbeef, 1'b0, 1'b1, 1, -1);
      for (int j = 0; j < LANES; j++) begin
        chk($sformatf("single_valid_l%0d_c%0d", j, k), 64'(io_out_valid[j]), 64'(j == k));
        chk($sformatf("single_a_l%0d_c%0d", j, k), 64'(io_out_a[j*DW +: DW]),
            (j == k) ? 64'(j + 1) : 64'(0));
      end
    end
    pulse_reset();

    // 3: eight back-to-back vectors, propagate flips after four
    for (int k = 0; k < 8; k++) begin
      dv = {8'(8'h40 + k), 8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k)};
      add(1'b1, dv, 1'b0, 1'b1, 1, enc(k >= 4, 1'b1, dv[7:0]));
    end
    for (int k = 0; k < 4; k++) add(1'b0, 32'h0, 1'b0, 1'b1, 1, -1);
    run_tbl();
    chk("b2b_cnt_wrap", 64'(dut.cnt_q), 64'(0));
    chk("b2b_prop_reg", 64'(dut.prop_q), 64'(0));

    // 4: last on the second vector of a tile -> two pad vectors
    add(1'b1, 32'ha4a3a2a1, 1'b0, 1'b1, 1, enc(1'b0, 1'b1, 8'ha1));
    add(1'b1, 32'hb4b3b2b1, 1'b1, 1'b1, 1, enc(1'b0, 1'b1, 8'hb1));
    add(1'b1, 32'hc4c3c2c1, 1'b0, 1'b1, 0, enc(1'b0, 1'b1, 8'h00));
    add(1'b1, 32'hc4c3c2c1, 1'b0, 1'b1, 0, enc(1'b0, 1'b1, 8'h00));
    add(1'b1, 32'hc4c3c2c1, 1'b0, 1'b1, 1, enc(1'b1, 1'b1, 8'hc1));
    // 5: enable drop for 3 cycles, last raised during the drop is ignored
    add(1'b1, 32'hd4d3d2d1, 1'b0, 1'b1, 1, enc(1'b1, 1'b1, 8'hd1));
    add(1'b1, 32'he4e3e2e1, 1'b1, 1'b0, 0, enc(1'b1, 1'b1, 8'hd1));
    add(1'b1, 32'he4e3e2e1, 1'b1, 1'b0, 0, enc(1'b1, 1'b1, 8'hd1));
    add(1'b1, 32'he4e3e2e1, 1'b1, 1'b0, 0, enc(1'b1, 1'b1, 8'hd1));
    add(1'b1, 32'he4e3e2e1, 1'b0, 1'b1, 1, enc(1'b1, 1'b1, 8'he1));
    add(1'b1, 32'hf4f3f2f1, 1'b0, 1'b1, 1, enc(1'b1, 1'b1, 8'hf1));
    // 6: move into a prop=1 phase, then start padding
    for (int k = 0; k < 4; k++) add(1'b1, 32'h11111111 * (k + 1), 1'b0, 1'b1, 1, -1);
    add(1'b1, 32'h55667788, 1'b1, 1'b1, 1, enc(1'b1, 1'b1, 8'h88));
    add(1'b1, 32'h99999999, 1'b0, 1'b1, 0, enc(1'b1, 1'b1, 8'h00));
    run_tbl();
    pulse_reset();
    add(1'b1, 32'h0a0b0c0d, 1'b0, 1'b1, 1, enc(1'b0, 1'b1, 8'h0d));
    for (int k = 0; k < 4; k++) add(1'b0, 32'h0, 1'b0, 1'b1, 1, -1);
    run_tbl();

    // random traffic against the scoreboard
    for (int k = 0; k < 80; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 4) != 0), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
